// File: rtl/vol_pkg.sv
// Shared constants and FSM state type for the plane-volume integrator.
//   SURF_W : default width of one plane-surface sample
//   DZ_W   : default width of the plane-spacing operand
//   ACC_W  : trapezoid accumulator width; holds twice the volume, so no overflow
//   VOL_W  : width of the reported volume (acc with its LSB dropped)
//   NP_W   : width of the plane count
package vol_pkg;

    localparam int unsigned SURF_W = 32;
    localparam int unsigned DZ_W   = 8;
    localparam int unsigned ACC_W  = 49;
    localparam int unsigned VOL_W  = 48;
    localparam int unsigned NP_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        ACCUM,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/trapz_mac.sv
// Trapezoid multiply-accumulate pipeline.
// Stage 1 registers sum = prev + surf; stage 2 adds sum * dz into acc.
// Ports:
//   clk, rst   : clock and asynchronous active-low reset
//   clear      : synchronous clear of the whole pipeline (new scan)
//   enable     : a new (prev, surf) pair is presented this cycle
//   prev, surf : the two plane surfaces bounding one slab
//   dz         : plane spacing for the current scan
//   sum_valid  : stage-1 register holds a sum not yet accumulated
//   acc        : running sum of (S[k-1] + S[k]) * dz, i.e. twice the volume
module trapz_mac
    import vol_pkg::*;
#(
    parameter int unsigned SURF_W = 32,
    parameter int unsigned DZ_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [SURF_W-1:0] prev,
    input  logic [SURF_W-1:0] surf,
    input  logic [DZ_W-1:0]   dz,
    output logic              sum_valid,
    output logic [ACC_W-1:0]  acc
);

    localparam int unsigned SUM_W  = SURF_W + 1;
    localparam int unsigned PROD_W = SUM_W + DZ_W;

    logic [SUM_W-1:0]  sum_q;
    logic [PROD_W-1:0] prod;

    // Widen both operands first so the product is not truncated to SUM_W.
    assign prod = PROD_W'(sum_q) * PROD_W'(dz);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q     <= '0;
            sum_valid <= 1'b0;
            acc       <= '0;
        end else if (clear) begin
            sum_q     <= '0;
            sum_valid <= 1'b0;
            acc       <= '0;
        end else begin
            sum_valid <= enable;
            if (enable) begin
                sum_q <= SUM_W'(prev) + SUM_W'(surf);
            end
            if (sum_valid) begin
                acc <= acc + ACC_W'(prod);
            end
        end
    end

endmodule

// File: rtl/plane_volume_integ.sv
// Plane-volume integrator: trapezoidal integration of a stream of plane
// surfaces, vol = floor(sum_{k=1..N-1} (S[k-1] + S[k]) * dz / 2).
// Ports:
//   clk, rst   : clock and asynchronous active-low reset
//   start      : one-cycle scan start; n_planes and dz are sampled with it
//   n_planes   : number of planes N in the scan
//   dz         : plane spacing
//   abort      : synchronous scan cancel, dominates surf_valid and start
//   surf_valid : strobe qualifying surf
//   surf       : plane surface sample
//   busy       : scan in progress
//   vol_valid  : one-cycle result strobe
//   vol        : scan volume, held until the next result or reset
module plane_volume_integ
    import vol_pkg::*;
#(
    parameter int unsigned SURF_W = 32,
    parameter int unsigned DZ_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NP_W-1:0]   n_planes,
    input  logic [DZ_W-1:0]   dz,
    input  logic              abort,
    input  logic              surf_valid,
    input  logic [SURF_W-1:0] surf,
    output logic              busy,
    output logic              vol_valid,
    output logic [VOL_W-1:0]  vol
);

    state_e            state;
    logic [NP_W-1:0]   n_q;
    logic [NP_W-1:0]   count;
    logic [DZ_W-1:0]   dz_q;
    logic [SURF_W-1:0] prev;

    logic              start_acc;
    logic              mac_en;
    logic              mac_pending;
    logic [ACC_W-1:0]  acc;

    assign start_acc = (state == IDLE) && start && !abort;
    assign mac_en    = (state == ACCUM) && surf_valid && !abort;

    trapz_mac #(
        .SURF_W (SURF_W),
        .DZ_W   (DZ_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc),
        .enable    (mac_en),
        .prev      (prev),
        .surf      (surf),
        .dz        (dz_q),
        .sum_valid (mac_pending),
        .acc       (acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            n_q       <= '0;
            count     <= '0;
            dz_q      <= '0;
            prev      <= '0;
            busy      <= 1'b0;
            vol_valid <= 1'b0;
            vol       <= '0;
        end else begin
            vol_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        n_q   <= n_planes;
                        dz_q  <= dz;
                        count <= '0;
                        busy  <= 1'b1;
                        // Fewer than two planes bound no slab: report zero directly.
                        state <= (n_planes >= NP_W'(2)) ? FIRST : DONE;
                    end
                end
                FIRST: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (surf_valid) begin
                        prev  <= surf;
                        count <= NP_W'(1);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (surf_valid) begin
                        prev  <= surf;
                        count <= count + NP_W'(1);
                        if (count + NP_W'(1) == n_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave once the last sum has been folded into acc.
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!mac_pending) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        vol       <= acc[ACC_W-1:1];
                        vol_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plane_volume_integ.sv
// Directed bench for plane_volume_integ with a scoreboard of expected volumes.
module tb_plane_volume_integ;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  n_planes;
    logic [7:0]  dz;
    logic        abort;
    logic        surf_valid;
    logic [31:0] surf;
    logic        busy;
    logic        vol_valid;
    logic [47:0] vol;

    int tests;
    int fails;

    logic [47:0]     exp_q[$];
    longint unsigned stim[$];

    plane_volume_integ dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_planes   (n_planes),
        .dz         (dz),
        .abort      (abort),
        .surf_valid (surf_valid),
        .surf       (surf),
        .busy       (busy),
        .vol_valid  (vol_valid),
        .vol        (vol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint unsigned got,
                         input longint unsigned expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Pop the next expected volume and wait for the result strobe.
    task automatic expect_result(input string tag, input int lat);
        logic [47:0] expv;
        bit          found;
        expv  = exp_q.pop_front();
        found = 1'b0;
        for (int i = 1; i <= 12 && !found; i++) begin
            step();
            if (vol_valid) begin
                found = 1'b1;
                check({tag, "_latency"}, i, lat);
                check({tag, "_vol"}, vol, expv);
                check({tag, "_busy_clear"}, busy, 0);
            end
        end
        check({tag, "_vol_valid_seen"}, found, 1);
        step();
        check({tag, "_vol_valid_one_cycle"}, vol_valid, 0);
    endtask

    task automatic do_start(input int n, input int d);
        start    = 1'b1;
        n_planes = n[7:0];
        dz       = d[7:0];
        step();
        start    = 1'b0;
    endtask

    // Drive the surfaces in stim, gap idle cycles between samples; the model
    // accumulates twice the volume and the expectation is pushed afterwards.
    task automatic feed(input int d, input int gap, input string tag);
        longint unsigned m_acc;
        longint unsigned m_prev;
        m_acc  = 0;
        m_prev = 0;
        for (int i = 0; i < stim.size(); i++) begin
            surf_valid = 1'b1;
            surf       = stim[i][31:0];
            if (i > 0) m_acc += (m_prev + stim[i]) * longint'(d);
            m_prev = stim[i];
            step();
            surf_valid = 1'b0;
            check({tag, "_busy"}, busy, 1);
            if (i != stim.size() - 1) repeat (gap) step();
        end
        exp_q.push_back(48'(m_acc >> 1));
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b0;
        start      = 1'b0;
        n_planes   = '0;
        dz         = '0;
        abort      = 1'b0;
        surf_valid = 1'b0;
        surf       = '0;

        repeat (3) step();
        check("reset_busy", busy, 0);
        check("reset_vol_valid", vol_valid, 0);
        check("reset_vol", vol, 0);
        rst = 1'b1;
        step();

        // Two planes with idle gaps between strobes: (10+20)*1/2 = 15.
        stim = '{10, 20};
        do_start(2, 1);
        check("t2_busy_start", busy, 1);
        feed(1, 2, "t2");
        expect_result("t2", 3);

        // Four planes back to back, dz=2: (300+500+700)*2/2 = 1500.
        stim = '{100, 200, 300, 400};
        do_start(4, 2);
        feed(2, 0, "t4");
        expect_result("t4", 3);

        // Odd doubled area truncates: 21/2 = 10.
        stim = '{10, 11};
        do_start(2, 1);
        feed(1, 0, "trunc");
        expect_result("trunc", 3);

        // Single plane: zero volume one cycle after start, no surf consumed.
        stim = {};
        do_start(1, 7);
        check("n1_busy_start", busy, 1);
        exp_q.push_back(48'd0);
        expect_result("n1", 1);
        surf_valid = 1'b1;
        surf       = 32'd99;
        step();
        surf_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("n1_stray_surf_no_valid", vol_valid, 0);
            check("n1_stray_surf_idle", busy, 0);
            step();
        end

        // Full-scale scan: 254*255*(2^32-1) = 278185031697150 (0xFD01_FFFF_02FE).
        stim = {};
        for (int i = 0; i < 255; i++) stim.push_back(64'hFFFF_FFFF);
        do_start(255, 255);
        feed(255, 0, "max");
        expect_result("max", 3);

        // Start together with abort in IDLE is ignored.
        start    = 1'b1;
        abort    = 1'b1;
        n_planes = 8'd3;
        dz       = 8'd1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_ignored", busy, 0);

        // Asynchronous reset mid-scan clears outputs immediately.
        do_start(4, 1);
        surf_valid = 1'b1;
        surf       = 32'd5;
        step();
        surf = 32'd6;
        step();
        surf_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_vol_valid", vol_valid, 0);
        check("rst_mid_vol", vol, 0);
        #2;
        rst = 1'b1;
        surf_valid = 1'b1;
        surf       = 32'd7;
        step();
        step();
        surf_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_after_no_valid", vol_valid, 0);
            step();
        end
        check("rst_after_idle", busy, 0);

        // Establish vol = 15, then abort a scan after its second surface.
        stim = '{10, 20};
        do_start(2, 1);
        feed(1, 0, "pre_abort");
        expect_result("pre_abort", 3);
        do_start(4, 3);
        surf_valid = 1'b1;
        surf       = 32'd50;
        step();
        surf = 32'd60;
        step();
        surf_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            check("abort_no_valid", vol_valid, 0);
            step();
        end
        check("abort_vol_kept", vol, 15);

        // Scan after abort: (12+16)*3/2 = 42.
        stim = '{5, 7, 9};
        do_start(3, 3);
        feed(3, 1, "post_abort");
        expect_result("post_abort", 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
